senone_max_tracker: RTL and testbench

//  Parametrised successor to the single-register score maximiser.
//  - Streams one senone score per valid beat over a frame.
//  - Tracks the running best score and the in-frame index of that senone.
//  - Flags frame completion and index overflow.
//  - Sits between the senone scoring pipeline and the HMM/beam-pruning stage;

---
 rtl/senone_max_tracker.sv | 142 ++++++++++++++
 tb/tb_senone_max_tracker.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/senone_max_tracker.sv
// Streaming senone score maximiser: tracks best score, its first in-frame index and beat count per frame.
// Optional beam threshold output enabled by defining SENONE_BEAM_THRESH_EN.
module senone_max_tracker #(
   parameter int SCORE_W = 16,
   parameter int IDX_W   = 13,
   parameter int BEAM    = 1024
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               frame_clear,
   input  logic               score_valid,
   input  logic               score_last,
   input  logic [SCORE_W-1:0] score_in,
   output logic [SCORE_W-1:0] best_score,
   output logic [IDX_W-1:0]   best_index,
   output logic [IDX_W-1:0]   beat_count,
   output logic               busy,
   output logic               max_done,
   output logic               idx_overflow,
   output logic [SCORE_W-1:0] beam_thresh
);

   typedef enum logic [1:0] {
      IDLE,
      ACCUM,
      DONE
   } state_t;

   localparam logic [SCORE_W-1:0] SCORE_MIN = {1'b1, {(SCORE_W-1){1'b0}}};
   localparam logic [IDX_W-1:0]   IDX_MAX   = '1;
   localparam logic [IDX_W-1:0]   IDX_ONE   = {{(IDX_W-1){1'b0}}, 1'b1};

   if (BEAM < 0 || BEAM >= 2 ** (SCORE_W - 1)) begin : g_beam_range
      $error("senone_max_tracker: BEAM out of range");
   end

   state_t             state_q, state_d;
   logic [SCORE_W-1:0] best_score_q, best_score_d;
   logic [IDX_W-1:0]   best_index_q, best_index_d;
   logic [IDX_W-1:0]   beat_count_q, beat_count_d;
   logic               idx_overflow_q, idx_overflow_d;
   logic               max_done_q, max_done_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= IDLE;
         best_score_q   <= SCORE_MIN;
         best_index_q   <= '0;
         beat_count_q   <= '0;
         idx_overflow_q <= 1'b0;
         max_done_q     <= 1'b0;
      end else begin
         state_q        <= state_d;
         best_score_q   <= best_score_d;
         best_index_q   <= best_index_d;
         beat_count_q   <= beat_count_d;
         idx_overflow_q <= idx_overflow_d;
         max_done_q     <= max_done_d;
      end
   end

   // A valid beat always advances the frame; score_last decides whether it closes it.
   always_comb begin
      state_d = state_q;
      if (frame_clear) begin
         state_d = IDLE;
      end else if (score_valid) begin
         state_d = score_last ? DONE : ACCUM;
      end
   end

   always_comb begin
      best_score_d   = best_score_q;
      best_index_d   = best_index_q;
      beat_count_d   = beat_count_q;
      idx_overflow_d = idx_overflow_q;
      max_done_d     = 1'b0;
      if (frame_clear) begin
         best_score_d   = SCORE_MIN;
         best_index_d   = '0;
         beat_count_d   = '0;
         idx_overflow_d = 1'b0;
      end else if (score_valid) begin
         max_done_d = score_last;
         if (state_q != ACCUM) begin
            best_score_d   = score_in;
            best_index_d   = '0;
            beat_count_d   = IDX_ONE;
            idx_overflow_d = 1'b0;
         end else begin
            // Strict compare keeps the earliest index on ties; the counter pins at its max on overflow.
            if ($signed(score_in) > $signed(best_score_q)) begin
               best_score_d = score_in;
               best_index_d = beat_count_q;
            end
            if (beat_count_q == IDX_MAX) begin
               idx_overflow_d = 1'b1;
            end else begin
               beat_count_d = beat_count_q + IDX_ONE;
            end
         end
      end
   end

   always_comb begin
      busy         = (state_q == ACCUM);
      max_done     = max_done_q;
      best_score   = best_score_q;
      best_index   = best_index_q;
      beat_count   = beat_count_q;
      idx_overflow = idx_overflow_q;
   end

`ifdef SENONE_BEAM_THRESH_EN
   localparam logic [SCORE_W:0] BEAM_EXT = (SCORE_W + 1)'(BEAM);

   logic [SCORE_W:0]   beam_diff;
   logic [SCORE_W-1:0] beam_thresh_q, beam_thresh_d;

   // Derived from the next best score so the threshold lands in the same cycle as best_score.
   always_comb begin
      beam_diff     = {best_score_d[SCORE_W-1], best_score_d} - BEAM_EXT;
      beam_thresh_d = beam_diff[SCORE_W-1:0];
      if (beam_diff[SCORE_W] != beam_diff[SCORE_W-1]) begin
         beam_thresh_d = SCORE_MIN;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         beam_thresh_q <= SCORE_MIN;
      end else begin
         beam_thresh_q <= beam_thresh_d;
      end
   end

   assign beam_thresh = beam_thresh_q;
`else
   assign beam_thresh = SCORE_MIN;
`endif

endmodule

// File: tb/tb_senone_max_tracker.sv
// Bench for senone_max_tracker: directed vector table, overflow/beam sequences and random frames
// checked against a frame-level reference model; a second instance uses IDX_W=3 for overflow.
module tb_senone_max_tracker;

   localparam int SW   = 16;
   localparam int IWA  = 13;
   localparam int IWB  = 3;
   localparam int BEAM = 1024;
   localparam int SMIN = -32768;

   logic                 clk = 1'b0;
   logic                 reset, frame_clear, score_valid, score_last;
   logic [SW-1:0]        score_in;
   logic signed [SW-1:0] best_a, beam_a, best_b, beam_b;
   logic [IWA-1:0]       idx_a, cnt_a;
   logic [IWB-1:0]       idx_b, cnt_b;
   logic                 busy_a, done_a, ovf_a, busy_b, done_b, ovf_b;

   int checks = 0;
   int errors = 0;

   int frame_q[$];
   bit m_busy = 1'b0;
   bit m_done = 1'b0;

   typedef struct {
      bit rst; bit clr; bit v; bit l; int s;
      int eb; int ei; int ec; bit ebusy; bit edone;
   } vec_t;

   vec_t vecs[$];

   always #5 clk = ~clk;

   senone_max_tracker #(.SCORE_W(SW), .IDX_W(IWA), .BEAM(BEAM)) dut_a (
      .clk(clk), .reset(reset), .frame_clear(frame_clear), .score_valid(score_valid),
      .score_last(score_last), .score_in(score_in), .best_score(best_a), .best_index(idx_a),
      .beat_count(cnt_a), .busy(busy_a), .max_done(done_a), .idx_overflow(ovf_a),
      .beam_thresh(beam_a)
   );

   senone_max_tracker #(.SCORE_W(SW), .IDX_W(IWB), .BEAM(BEAM)) dut_b (
      .clk(clk), .reset(reset), .frame_clear(frame_clear), .score_valid(score_valid),
      .score_last(score_last), .score_in(score_in), .best_score(best_b), .best_index(idx_b),
      .beat_count(cnt_b), .busy(busy_b), .max_done(done_b), .idx_overflow(ovf_b),
      .beam_thresh(beam_b)
   );

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Drive one cycle, advance the frame model on the same edge, then settle past the edge.
   task automatic applyStimulus(input bit rst, input bit clr, input bit v, input bit l, input int s);
      reset       = rst;
      frame_clear = clr;
      score_valid = v;
      score_last  = l;
      score_in    = 16'(s);
      @(posedge clk);
      if (rst || clr) begin
         frame_q.delete();
         m_busy = 1'b0;
         m_done = 1'b0;
      end else begin
         m_done = v && l;
         if (v) begin
            if (!m_busy) frame_q.delete();
            frame_q.push_back(s);
            m_busy = !l;
         end
      end
      #1;
   endtask

   function automatic int modelBest();
      int b = SMIN;
      foreach (frame_q[i]) if (i == 0 || frame_q[i] > b) b = frame_q[i];
      return b;
   endfunction

   function automatic int modelFirstIdx();
      int b = SMIN;
      int f = 0;
      foreach (frame_q[i]) if (i == 0 || frame_q[i] > b) begin b = frame_q[i]; f = i; end
      return f;
   endfunction

   function automatic int minInt(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

   function automatic int modelBeam(input int b);
`ifdef SENONE_BEAM_THRESH_EN
      return (b - BEAM < SMIN) ? SMIN : b - BEAM;
`else
      return SMIN;
`endif
   endfunction

   task automatic checkOutput();
      int eb, fi, n, ma, mb;
      eb = modelBest();
      fi = modelFirstIdx();
      n  = frame_q.size();
      ma = (1 << IWA) - 1;
      mb = (1 << IWB) - 1;
      check("a_best", best_a, eb);
      check("a_index", idx_a, minInt(fi, ma));
      check("a_count", cnt_a, minInt(n, ma));
      check("a_busy", busy_a, m_busy);
      check("a_done", done_a, m_done);
      check("a_ovf", ovf_a, (n > ma) ? 1 : 0);
      check("a_beam", beam_a, modelBeam(eb));
      check("b_best", best_b, eb);
      check("b_index", idx_b, minInt(fi, mb));
      check("b_count", cnt_b, minInt(n, mb));
      check("b_busy", busy_b, m_busy);
      check("b_done", done_b, m_done);
      check("b_ovf", ovf_b, (n > mb) ? 1 : 0);
      check("b_beam", beam_b, modelBeam(eb));
   endtask

   task automatic addVec(input bit rst, input bit clr, input bit v, input bit l, input int s,
                         input int eb, input int ei, input int ec, input bit ebusy, input bit edone);
      vec_t t;
      t.rst = rst; t.clr = clr; t.v = v; t.l = l; t.s = s;
      t.eb = eb; t.ei = ei; t.ec = ec; t.ebusy = ebusy; t.edone = edone;
      vecs.push_back(t);
   endtask

   initial begin
      int s, r;
      bit rv, cv, vv, lv;

      addVec(1, 0, 0, 0,      0, SMIN, 0, 0, 0, 0);
      addVec(0, 0, 1, 0,      5,    5, 0, 1, 1, 0);
      addVec(0, 0, 1, 0,     -3,    5, 0, 2, 1, 0);
      addVec(0, 0, 1, 0,     12,   12, 2, 3, 1, 0);
      addVec(0, 0, 1, 1,      7,   12, 2, 4, 0, 1);
      addVec(0, 0, 0, 0,      0,   12, 2, 4, 0, 0);
      addVec(0, 0, 1, 0,   SMIN, SMIN, 0, 1, 1, 0);
      addVec(0, 0, 1, 0,   SMIN, SMIN, 0, 2, 1, 0);
      addVec(0, 0, 1, 1,   SMIN, SMIN, 0, 3, 0, 1);
      addVec(0, 0, 1, 0,      9,    9, 0, 1, 1, 0);
      addVec(0, 0, 1, 0,      9,    9, 0, 2, 1, 0);
      addVec(0, 0, 1, 1,      4,    9, 0, 3, 0, 1);
      addVec(0, 0, 1, 0,      1,    1, 0, 1, 1, 0);
      addVec(0, 0, 1, 1,      2,    2, 1, 2, 0, 1);
      addVec(0, 0, 1, 0,    100,  100, 0, 1, 1, 0);
      addVec(0, 1, 1, 0,     50, SMIN, 0, 0, 0, 0);
      addVec(0, 0, 0, 0,      0, SMIN, 0, 0, 0, 0);
      addVec(0, 0, 1, 1,      3,    3, 0, 1, 0, 1);
      addVec(0, 0, 0, 1,    999,    3, 0, 1, 0, 0);
      addVec(1, 0, 1, 0,      5, SMIN, 0, 0, 0, 0);

      $display("[TB] directed vector table");
      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i].rst, vecs[i].clr, vecs[i].v, vecs[i].l, vecs[i].s);
         checkOutput();
         check($sformatf("vec%0d_best", i), best_a, vecs[i].eb);
         check($sformatf("vec%0d_index", i), idx_a, vecs[i].ei);
         check($sformatf("vec%0d_count", i), cnt_a, vecs[i].ec);
         check($sformatf("vec%0d_busy", i), busy_a, vecs[i].ebusy);
         check($sformatf("vec%0d_done", i), done_a, vecs[i].edone);
      end

      $display("[TB] overflow sequence");
      applyStimulus(1, 0, 0, 0, 0);
      for (int i = 0; i < 9; i++) begin
         s = (i == 7) ? 50 : ((i == 8) ? 20 : 10);
         applyStimulus(0, 0, 1, (i == 8), s);
         checkOutput();
      end
      check("ovf_b_count", cnt_b, 7);
      check("ovf_b_flag", ovf_b, 1);
      check("ovf_b_index", idx_b, 7);
      check("ovf_b_best", best_b, 50);
      check("ovf_a_count", cnt_a, 9);
      check("ovf_a_flag", ovf_a, 0);
      applyStimulus(0, 0, 1, 0, 1);
      checkOutput();
      check("ovf_b_cleared", ovf_b, 0);
      check("ovf_b_restart", cnt_b, 1);

      $display("[TB] beam threshold sequence");
      applyStimulus(0, 0, 1, 1, 3000);
      checkOutput();
`ifdef SENONE_BEAM_THRESH_EN
      check("beam_3000", beam_a, 1976);
`else
      check("beam_3000", beam_a, SMIN);
`endif
      applyStimulus(0, 0, 1, 1, -32000);
      checkOutput();
      check("beam_clamp", beam_a, SMIN);

      $display("[TB] random frames");
      for (int c = 0; c < 3000; c++) begin
         rv = ($urandom_range(0, 299) == 0);
         cv = ($urandom_range(0, 49) == 0);
         vv = ($urandom_range(0, 9) < 7);
         lv = ($urandom_range(0, 9) == 0);
         r  = $urandom_range(0, 9);
         if (r == 0)      s = SMIN;
         else if (r == 1) s = 32767;
         else if (r < 5)  s = $urandom_range(0, 8) - 4;
         else             s = $urandom_range(0, 65535) - 32768;
         applyStimulus(rv, cv, vv, lv, s);
         checkOutput();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
